// File: rtl/time_set_input.sv
// ============================================================================
// Module   : time_set_input
// Purpose  : Debounced five-button MM:SS editor with a BCD step engine and a
//            one-cycle load strobe. Optional: TIME_SET_AUTOREPEAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module time_set_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic [3:0] cur_sec_units,
    input  logic [2:0] cur_sec_tens,
    input  logic [3:0] cur_min_units,
    input  logic [2:0] cur_min_tens,
    output logic [3:0] set_sec_units,
    output logic [2:0] set_sec_tens,
    output logic [3:0] set_min_units,
    output logic [2:0] set_min_tens,
    output logic       load,
    output logic       edit_active,
    output logic       edit_field
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BC   = 4;
    localparam int BU   = 3;
    localparam int BD   = 2;
    localparam int BL   = 1;
    localparam int BR   = 0;

    typedef enum logic [1:0] {IDLE, EDIT_SEC, EDIT_MIN, COMMIT} state_t;
    state_t state;

    logic [4:0] raw;
    logic [4:0] level;
    logic [4:0] level_prev;
    logic [4:0] pulse;

    assign raw = {btn_c, btn_u, btn_d, btn_l, btn_r};

    generate
        for (genvar i = 0; i < 5; i++) begin : g_btn
            logic            sync1;
            logic            sync2;
            logic            level_q;
            logic            level_d;
            logic [DB_W-1:0] cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1   <= 1'b0;
                    sync2   <= 1'b0;
                    level_q <= 1'b0;
                    level_d <= 1'b0;
                    cnt     <= '0;
                end else begin
                    sync1   <= raw[i];
                    sync2   <= sync1;
                    level_d <= level_q;
                    // Any cycle agreeing with the accepted level restarts the count.
                    if (sync2 != level_q) begin
                        if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                            level_q <= sync2;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + DB_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
            end

            assign level[i]      = level_q;
            assign level_prev[i] = level_d;
        end
    endgenerate

    assign pulse = level & ~level_prev;

    logic in_edit;
    assign in_edit = (state == EDIT_SEC) || (state == EDIT_MIN);

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_hold;
    logic             rpt_fire;

    // Exactly one of up/down held; both held is treated like a simultaneous press.
    assign rpt_hold = (level[BU] ^ level[BD]) && in_edit;
    assign rpt_fire = rpt_hold && !pulse[BU] && !pulse[BD]
                      && (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_cnt <= '0;
        end else if (!rpt_hold || pulse[BU] || pulse[BD] || rpt_fire) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end
`endif

    logic press_c, step_up, step_dn, go_min, go_sec;

    always_comb begin
        press_c = pulse[BC];
        step_up = !press_c && pulse[BU] && !pulse[BD];
        step_dn = !press_c && pulse[BD] && !pulse[BU];
        go_min  = !press_c && pulse[BL] && !pulse[BR];
        go_sec  = !press_c && pulse[BR] && !pulse[BL];
`ifdef TIME_SET_AUTOREPEAT_EN
        if (rpt_fire && !press_c) begin
            step_up = level[BU];
            step_dn = level[BD];
        end
`endif
    end

    function automatic logic [6:0] bcd_clamp(input logic [2:0] t, input logic [3:0] u);
        bcd_clamp = {(t > 3'd5) ? 3'd5 : t, (u > 4'd9) ? 4'd9 : u};
    endfunction

    function automatic logic [6:0] bcd_inc(input logic [2:0] t, input logic [3:0] u);
        if (u >= 4'd9) bcd_inc = {(t >= 3'd5) ? 3'd0 : t + 3'd1, 4'd0};
        else           bcd_inc = {t, u + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_dec(input logic [2:0] t, input logic [3:0] u);
        if (u == 4'd0) bcd_dec = {(t == 3'd0) ? 3'd5 : t - 3'd1, 4'd9};
        else           bcd_dec = {t, u - 4'd1};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            set_sec_units <= 4'd0;
            set_sec_tens  <= 3'd0;
            set_min_units <= 4'd0;
            set_min_tens  <= 3'd0;
            load          <= 1'b0;
            edit_active   <= 1'b0;
            edit_field    <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_c) begin
                        state       <= EDIT_SEC;
                        edit_active <= 1'b1;
                        edit_field  <= 1'b0;
                        {set_sec_tens, set_sec_units} <= bcd_clamp(cur_sec_tens, cur_sec_units);
                        {set_min_tens, set_min_units} <= bcd_clamp(cur_min_tens, cur_min_units);
                    end
                end
                EDIT_SEC, EDIT_MIN: begin
                    if (press_c) begin
                        state <= COMMIT;
                        load  <= 1'b1;
                    end else begin
                        if (state == EDIT_SEC && go_min) begin
                            state      <= EDIT_MIN;
                            edit_field <= 1'b1;
                        end
                        if (state == EDIT_MIN && go_sec) begin
                            state      <= EDIT_SEC;
                            edit_field <= 1'b0;
                        end
                        if (state == EDIT_SEC) begin
                            if (step_up)
                                {set_sec_tens, set_sec_units} <= bcd_inc(set_sec_tens, set_sec_units);
                            else if (step_dn)
                                {set_sec_tens, set_sec_units} <= bcd_dec(set_sec_tens, set_sec_units);
                        end else begin
                            if (step_up)
                                {set_min_tens, set_min_units} <= bcd_inc(set_min_tens, set_min_units);
                            else if (step_dn)
                                {set_min_tens, set_min_units} <= bcd_dec(set_min_tens, set_min_units);
                        end
                    end
                end
                COMMIT: begin
                    state       <= IDLE;
                    edit_active <= 1'b0;
                    edit_field  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_time_set_input.sv
// ============================================================================
// Module   : tb_time_set_input
// Purpose  : Directed self-checking bench for time_set_input.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_time_set_input;

    localparam logic [4:0] C = 5'b10000;
    localparam logic [4:0] U = 5'b01000;
    localparam logic [4:0] D = 5'b00100;
    localparam logic [4:0] L = 5'b00010;
    localparam logic [4:0] R = 5'b00001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic [3:0] cur_sec_units = 4'd0, cur_min_units = 4'd0;
    logic [2:0] cur_sec_tens = 3'd0, cur_min_tens = 3'd0;
    logic [3:0] set_sec_units, set_min_units;
    logic [2:0] set_sec_tens, set_min_tens;
    logic       load, edit_active, edit_field;

    int          checks = 0;
    int          errors = 0;
    int          load_cnt = 0;
    logic [13:0] load_val = '0;

    always #5 clk = ~clk;

    time_set_input #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_c        (btn_c),
        .btn_u        (btn_u),
        .btn_d        (btn_d),
        .btn_l        (btn_l),
        .btn_r        (btn_r),
        .cur_sec_units(cur_sec_units),
        .cur_sec_tens (cur_sec_tens),
        .cur_min_units(cur_min_units),
        .cur_min_tens (cur_min_tens),
        .set_sec_units(set_sec_units),
        .set_sec_tens (set_sec_tens),
        .set_min_units(set_min_units),
        .set_min_tens (set_min_tens),
        .load         (load),
        .edit_active  (edit_active),
        .edit_field   (edit_field)
    );

    function automatic logic [13:0] tv(input int m, input int s);
        tv = {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [13:0] set_now();
        set_now = {set_min_tens, set_min_units, set_sec_tens, set_sec_units};
    endfunction

    always @(negedge clk) begin
        if (load) begin
            load_cnt++;
            load_val = set_now();
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] mask);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = mask;
    endtask

    task automatic set_cur(input int m, input int s);
        {cur_min_tens, cur_min_units, cur_sec_tens, cur_sec_units} = tv(m, s);
    endtask

    // Held long enough to debounce, released before any auto-repeat could fire.
    task automatic press(input logic [4:0] mask);
        drive(mask);
        repeat (6) @(negedge clk);
        drive(5'b0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        drive(5'b11111);
        set_cur(12, 58);
        repeat (3) @(negedge clk);
        check("rst_set", 32'(set_now()), 32'(tv(0, 0)));
        check("rst_load", 32'(load), 32'd0);
        check("rst_active", 32'(edit_active), 32'd0);
        check("rst_field", 32'(edit_field), 32'd0);

        drive(5'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("idle_no_load", 32'(load_cnt), 32'd0);
        check("idle_active", 32'(edit_active), 32'd0);

        press(C);
        check("entry_set", 32'(set_now()), 32'(tv(12, 58)));
        check("entry_active", 32'(edit_active), 32'd1);
        check("entry_field", 32'(edit_field), 32'd0);
        press(U);
        check("inc_59", 32'(set_now()), 32'(tv(12, 59)));
        press(U);
        check("inc_wrap_00", 32'(set_now()), 32'(tv(12, 0)));
        press(U);
        check("inc_01", 32'(set_now()), 32'(tv(12, 1)));
        press(C);
        check("commit_count", 32'(load_cnt), 32'd1);
        check("commit_val", 32'(load_val), 32'(tv(12, 1)));
        check("commit_inactive", 32'(edit_active), 32'd0);

        press(U);
        check("idle_u_ignored", 32'(set_now()), 32'(tv(12, 1)));

        set_cur(0, 30);
        press(C);
        check("entry2_set", 32'(set_now()), 32'(tv(0, 30)));
        for (int i = 0; i < 10; i++) begin
            btn_u = (i % 2 == 0);
            @(negedge clk);
        end
        press(U);
        check("bounce_one_step", 32'(set_now()), 32'(tv(0, 31)));
        press(D);
        check("dec_sec", 32'(set_now()), 32'(tv(0, 30)));
        press(L);
        check("sel_min", 32'(edit_field), 32'd1);
        press(D);
        check("dec_min_wrap", 32'(set_now()), 32'(tv(59, 30)));
        press(U | D);
        check("ud_ignored", 32'(set_now()), 32'(tv(59, 30)));
        press(L);
        check("l_in_min_noop", 32'(edit_field), 32'd1);
        press(R);
        check("sel_sec", 32'(edit_field), 32'd0);
        press(L);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midedit_rst_set", 32'(set_now()), 32'(tv(0, 0)));
        check("midedit_rst_active", 32'(edit_active), 32'd0);
        check("midedit_rst_field", 32'(edit_field), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("midedit_no_load", 32'(load_cnt), 32'd1);
        press(U);
        check("post_rst_idle", 32'(edit_active), 32'd0);
        check("post_rst_set", 32'(set_now()), 32'(tv(0, 0)));

        set_cur(0, 0);
        press(C);
        press(D);
        check("dec_sec_wrap", 32'(set_now()), 32'(tv(0, 59)));
        press(U);
        check("inc_sec_wrap", 32'(set_now()), 32'(tv(0, 0)));

        btn_u = 1'b1;
        repeat (30) @(negedge clk);
        btn_u = 1'b0;
        repeat (12) @(negedge clk);
`ifdef TIME_SET_AUTOREPEAT_EN
        check("hold_u", 32'(set_now()), 32'(tv(0, 4)));
`else
        check("hold_u", 32'(set_now()), 32'(tv(0, 1)));
`endif

        press(C | U);
        check("cu_commit_count", 32'(load_cnt), 32'd2);
`ifdef TIME_SET_AUTOREPEAT_EN
        check("cu_commit_val", 32'(load_val), 32'(tv(0, 4)));
`else
        check("cu_commit_val", 32'(load_val), 32'(tv(0, 1)));
`endif
        check("cu_inactive", 32'(edit_active), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/time_set_input.md
TIME_SET_INPUT -- requirements
Module: time_set_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
REQ-002 Parameter REPEAT_CYCLES, default 25000000, auto-repeat period while up/down is held (used only under TIME_SET_AUTOREPEAT_EN).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_c, btn_u, btn_d, btn_l, btn_r  input  1 each  raw asynchronous push-buttons: mode, up, down, select minutes, select seconds.
REQ-006 cur_sec_units, cur_min_units  input  4 each; cur_sec_tens, cur_min_tens  input  3 each  running time from the system counter, sampled on edit entry.
REQ-007 set_sec_units, set_min_units  output  4 each; set_sec_tens, set_min_tens  output  3 each  edited time value.
REQ-008 load  output  1  one-cycle strobe; counter shall load set_* on this cycle.
REQ-009 edit_active  output  1  high in EDIT_SEC/EDIT_MIN/COMMIT; counter shall hold while high.
REQ-010 edit_field  output  1  0 = seconds selected, 1 = minutes selected (display blinks the selected pair).

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer, then a debouncer whose accepted level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-012 A press pulse (1 cycle) SHALL assert the cycle after a debounced level rises 0->1; release generates no pulse.
REQ-013 FSM states IDLE, EDIT_SEC, EDIT_MIN, COMMIT; encoding is free.
REQ-014 IDLE + c-press -> EDIT_SEC; same cycle capture cur_* into set_* registers.
REQ-015 EDIT_SEC + l-press -> EDIT_MIN; EDIT_MIN + r-press -> EDIT_SEC; l in EDIT_MIN and r in EDIT_SEC are no-ops.
REQ-016 EDIT_SEC/EDIT_MIN + c-press -> COMMIT; COMMIT -> IDLE unconditionally next cycle; load=1 only in COMMIT.
REQ-017 u-press increments selected field as BCD 00..59: units 9->0 with tens carry, 59 wraps to 00; the other field is unaffected.
REQ-018 d-press decrements selected field: units 0->9 with tens borrow, 00 wraps to 59.
REQ-019 Updated set_* SHALL be visible the cycle after the press pulse (1-cycle latency).
REQ-020 Simultaneous u and d pulses: both ignored. c-pulse together with any other pulse: c wins, others discarded. l and r together: ignored.
REQ-021 In IDLE, u/d/l/r pulses are ignored and set_* hold their last value.
REQ-022 set_*_units never exceeds 9 and set_*_tens never exceeds 5 under any stimulus.

Reset
REQ-023 On reset low: state IDLE, all set_* = 0, load = 0, edit_active = 0, edit_field = 0, synchronizers, debounced levels and counters cleared, immediately and independent of clk.
REQ-024 Reset asserted mid-edit SHALL abandon the edit with no load strobe; after release a fresh c-press is required.

Configuration
REQ-025 With TIME_SET_AUTOREPEAT_EN defined, u or d held debounced-high in an edit state SHALL generate an extra step every REPEAT_CYCLES after the initial press pulse, until release or state exit.
REQ-026 Without TIME_SET_AUTOREPEAT_EN, exactly one step per press; REPEAT_CYCLES is unused and no repeat counter is synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-027 Reset low with buttons high -> all outputs 0, state IDLE; release, no presses -> load never asserts.
REQ-028 btn_u bouncing 1,0,1,0 every cycle for 10 cycles then stable 1 in EDIT_SEC -> exactly one increment.
REQ-029 cur=12:58, c-press, u,u,u -> set = 12:01 (seconds 58->59->00->01), minutes still 12; c-press -> load one cycle with 12:01, then IDLE, edit_active=0.
REQ-030 EDIT_MIN from 00:30, d-press -> 59:30; u and d pressed same cycle -> no change.
REQ-031 Reset low during EDIT_MIN -> IDLE, load stays 0, set_* = 0.
REQ-032 With TIME_SET_AUTOREPEAT_EN, hold u 30 cycles after debounce in EDIT_SEC from 00 -> 4 steps (press + 3 repeats), seconds = 04; without macro -> 01.
